// File: rtl/fir_ctrl_pkg.sv
// Shared types and sizing helpers for the FIR control blocks.
package fir_ctrl_pkg;

   localparam int DEF_TAPS        = 128;
   localparam int DEF_NCH         = 4;
   localparam int DEF_TIMEOUT     = 512;
   localparam int DEF_RECOVER_CYC = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_START,
      S_COMPUTE,
      S_RECOVER,
      S_COEFF
   } state_t;

   function automatic int cw_of(input int taps);
      return $clog2(taps) + 1;
   endfunction

   function automatic int chw_of(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter
   import fir_ctrl_pkg::*;
#(
   parameter int N  = DEF_NCH,
   parameter int PW = chw_of(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx
);

   int unsigned c;
   logic        found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         c = (32'(ptr) + i) % N;
         if (!found && req[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = PW'(c);
         end
      end
   end

endmodule

// File: rtl/fir_mc_sequencer.sv
// Multi-channel FIR control: per-channel ping-pong fill tracking, round-robin
// dispatch to a shared DA engine, watchdog recovery and deferred coefficient updates.
module fir_mc_sequencer
   import fir_ctrl_pkg::*;
#(
   parameter int TAPS        = DEF_TAPS,
   parameter int NCH         = DEF_NCH,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int RECOVER_CYC = DEF_RECOVER_CYC
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sample_valid,
   input  logic [chw_of(NCH)-1:0]  sample_ch,
   input  logic                    coeff_prog,
   input  logic                    comp_done,
   input  logic                    err_clr,
   output logic                    start,
   output logic [chw_of(NCH)-1:0]  start_ch,
   output logic [NCH-1:0]          buf_sel,
   output logic                    coeff_ack,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [NCH-1:0]          ovr_flags
);

   localparam int CW  = cw_of(TAPS);
   localparam int CHW = chw_of(NCH);
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int RW  = $clog2(RECOVER_CYC + 1);

   state_t          state, state_next;
   logic [CW-1:0]   fill_cnt [NCH];
   logic [NCH-1:0]  pending, fill_done, job_sel, arb_grant, pend_set, pend_clr;
   logic [CHW-1:0]  rr_ptr, arb_idx, next_ptr;
   logic [TW-1:0]   wd;
   logic [RW-1:0]   rec_cnt;
   logic            wd_expired, rec_last, to_event;

   rr_arbiter #(.N(NCH), .PW(CHW)) u_arb (
      .req   (pending),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   assign wd_expired = (wd == TW'(TIMEOUT - 1));
   assign rec_last   = (rec_cnt == RW'(RECOVER_CYC - 1));
   assign next_ptr   = (start_ch == CHW'(NCH - 1)) ? '0 : start_ch + 1'b1;
   assign to_event   = (state == S_COMPUTE) && !comp_done && wd_expired;

   always_comb begin
      fill_done = '0;
      job_sel   = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         fill_done[c] = sample_valid && (sample_ch == CHW'(c)) && (fill_cnt[c] == CW'(TAPS - 1));
         job_sel[c]   = (start_ch == CHW'(c));
      end
      pend_clr = (state == S_START) ? job_sel : '0;
      // A fill completing in the same cycle as the clear keeps its channel pending.
      pend_set = fill_done | (((state == S_RECOVER) && rec_last) ? job_sel : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: begin
            if (coeff_prog)    state_next = S_COEFF;
            else if (|pending) state_next = S_ARB;
         end
         S_ARB:     state_next = (|arb_grant) ? S_START : S_IDLE;
         S_START:   state_next = S_COMPUTE;
         S_COMPUTE: begin
            if (comp_done)       state_next = S_IDLE;
            else if (wd_expired) state_next = S_RECOVER;
         end
         S_RECOVER: if (rec_last) state_next = S_IDLE;
         S_COEFF:   if (!coeff_prog) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < NCH; c++) fill_cnt[c] <= '0;
         buf_sel     <= '0;
         pending     <= '0;
         ovr_flags   <= '0;
         timeout_err <= 1'b0;
         start_ch    <= '0;
         rr_ptr      <= '0;
         wd          <= '0;
         rec_cnt     <= '0;
      end else begin
         for (int unsigned c = 0; c < NCH; c++) begin
            if (sample_valid && (sample_ch == CHW'(c)))
               fill_cnt[c] <= fill_done[c] ? '0 : fill_cnt[c] + 1'b1;
         end
         buf_sel     <= buf_sel ^ fill_done;
         pending     <= (pending & ~pend_clr) | pend_set;
         ovr_flags   <= (err_clr ? '0 : ovr_flags) | (fill_done & pending);
         timeout_err <= (timeout_err & ~err_clr) | to_event;
         if ((state == S_ARB) && (|arb_grant)) start_ch <= arb_idx;
         if ((state == S_COMPUTE) && comp_done) rr_ptr <= next_ptr;
         wd      <= (state == S_COMPUTE) ? wd + 1'b1 : '0;
         rec_cnt <= (state == S_RECOVER) ? rec_cnt + 1'b1 : '0;
      end
   end

   assign start     = (state == S_START);
   assign coeff_ack = (state == S_COEFF);
   assign busy      = (state != S_IDLE);

endmodule

// File: doc/fir_mc_sequencer.md
Name: fir_mc_sequencer

Overview:
Multi-channel successor to the single-channel FIR control FSM. It tracks sample fill for NCH time-multiplexed channels and ping-pong buffers each channel independently. A round-robin arbiter picks one ready channel at a time for the shared DA engine. It supervises the engine with a watchdog, defers coefficient updates safely, and flags per-channel overruns.

Parameters:
TAPS, 128, samples per buffer (power of two, ≥4); CW = $clog2(TAPS)+1
NCH, 4, channel count (1..16); CHW = max(1,$clog2(NCH))
TIMEOUT, 512, max cycles START→done before error; TW = $clog2(TIMEOUT+1)
RECOVER_CYC, 8, cycles spent in RECOVER (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sample_valid  in  1  one sample accepted this cycle
sample_ch  in  CHW  channel of that sample (values ≥NCH ignored)
coeff_prog  in  1  coefficient programming request (level)
comp_done  in  1  DA engine completion pulse
err_clr  in  1  clears sticky error/overrun flags
start  out  1  one-cycle engine start pulse
start_ch  out  CHW  channel being computed (valid from start until done)
buf_sel  out  NCH  per-channel ping-pong select; engine reads bank ~buf_sel[c]
coeff_ack  out  1  high while in COEFF state
busy  out  1  state ≠ IDLE
timeout_err  out  1  sticky watchdog error
ovr_flags  out  NCH  sticky per-channel overrun

Behaviour:
- Reset: start=0, start_ch=0, buf_sel=0, coeff_ack=0, busy=0, timeout_err=0, ovr_flags=0. Counters, pending, and arbiter pointer are 0. State is IDLE. Reset mid-computation abandons the job with no done expected.
- Fill: on sample_valid with sample_ch<NCH, fill_cnt[ch]++. When the increment reaches TAPS, fill_cnt[ch]←0, buf_sel[ch] toggles, and pending[ch]←1 in the same cycle.
- Overrun: if the buffer completes while pending[ch] is already 1, set ovr_flags[ch]. buf_sel still toggles and pending stays 1, so the oldest result is lost.
- Filling continues in every state, including COEFF and RECOVER.
- FSM states: IDLE, ARB, START, COMPUTE, RECOVER, COEFF.
- IDLE: coeff_prog → COEFF (priority). Otherwise any pending → ARB.
- ARB: grant the first pending channel at or after rr_ptr, wrapping. Register start_ch. → START.
- START: start=1 for exactly one cycle. Clear pending[start_ch]. Load the watchdog to 0. → COMPUTE.
- COMPUTE: watchdog++ each cycle.
  - comp_done → IDLE and rr_ptr←start_ch+1 mod NCH.
  - Else watchdog==TIMEOUT-1 → RECOVER and timeout_err←1.
  - comp_done in the same cycle as the timeout wins (no error).
  - coeff_prog is ignored here and serviced from IDLE afterwards.
- RECOVER: hold RECOVER_CYC cycles. Re-set pending[start_ch] so the job retries. → IDLE. comp_done arriving in RECOVER is ignored.
- COEFF: coeff_ack=1. On coeff_prog deassert → IDLE. pending flags are preserved.
- Latency: IDLE with pending → start pulse 2 cycles later (IDLE→ARB→START).
- err_clr clears timeout_err and ovr_flags. A set event in the same cycle wins over the clear.
- comp_done outside COMPUTE is ignored. The sample that completes a buffer on the same cycle as ARB is eligible next arbitration, not this one.

Decomposition:
- Package fir_ctrl_pkg: state enum, default TAPS/NCH/TIMEOUT constants, CW/CHW helper functions.
- Sub-module rr_arbiter (NCH-wide request, pointer in, one-hot grant plus encoded index out), purely combinational, reused by other multi-channel blocks.

Test Plan:
- NCH=4, TAPS=8: 8 samples on ch2 → buf_sel=4'b0100, start 2 cycles after entering IDLE with start_ch=2. comp_done → busy drops next cycle.
- ch0 and ch3 fill simultaneously pending, rr_ptr=1 → ch3 granted first, then ch0 after its done.
- No comp_done for TIMEOUT=16 cycles → timeout_err=1, RECOVER lasts 8 cycles, then ch retried with start reasserted. err_clr → timeout_err=0.
- ch1 fills 16 samples while ch1 is pending behind a hung ch0 job → ovr_flags[1]=1, buf_sel[1] toggled twice (back to 0).
- coeff_prog asserted during COMPUTE → coeff_ack stays 0 until done, then rises 1 cycle after IDLE. Samples arriving in COEFF still increment fill.
- rst_n pulsed low mid-COMPUTE → all outputs 0 immediately. A late comp_done after reset produces no state change.
